// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter
// Shares one single-outstanding memory port between an instruction-fetch
// port and a load/store port. Exactly one transaction is in flight at a time.
//
// Ports
//   clk, resetn          : clock (rising edge) and asynchronous active-low reset
//   inst_req/inst_addr   : fetch request; inst_addr_ok accepts it (IDLE only)
//   inst_data_ok/rdata   : one-cycle completion pulse and read data for fetches
//   data_req/wr/wstrb/
//   addr/wdata           : load/store request; data_addr_ok accepts it
//   data_data_ok/rdata   : one-cycle completion pulse and read data for loads
//   mem_req/wr/wstrb/
//   addr/wdata           : request towards memory, held stable until accepted
//   mem_addr_ok          : memory accepted the request
//   mem_data_ok/rdata    : memory response
//
// Parameter DATA_FIRST: 1 = data port always wins a tie, 0 = round-robin.

module cpu_mem_arbiter #(
    parameter int DATA_FIRST = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ADDR = 2'd1,
        WAIT_DATA = 2'd2,
        RESP      = 2'd3
    } state_e;

    localparam logic DATA_PRIO = (DATA_FIRST != 0);

    state_e      state_q, state_d;
    logic        owner_data_q, owner_data_d;   // 1 = data port owns the transaction
    logic [31:0] addr_q, addr_d;
    logic        wr_q, wr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rr_data_q, rr_data_d;         // 1 = data port wins the next tie
    logic        grant_data_s;
    logic        grant_inst_s;

    // Arbitration in IDLE; gated by resetn so addr_ok is 0 while reset is held.
    always_comb begin
        grant_data_s = 1'b0;
        grant_inst_s = 1'b0;
        if (resetn && (state_q == IDLE)) begin
            if (data_req && inst_req) begin
                if (DATA_PRIO || rr_data_q) begin
                    grant_data_s = 1'b1;
                end else begin
                    grant_inst_s = 1'b1;
                end
            end else if (data_req) begin
                grant_data_s = 1'b1;
            end else if (inst_req) begin
                grant_inst_s = 1'b1;
            end else begin
                grant_data_s = 1'b0;
                grant_inst_s = 1'b0;
            end
        end else begin
            grant_data_s = 1'b0;
            grant_inst_s = 1'b0;
        end
    end

    // Next-state, request latching and read-data capture.
    always_comb begin
        state_d      = state_q;
        owner_data_d = owner_data_q;
        addr_d       = addr_q;
        wr_d         = wr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rr_data_d    = rr_data_q;
        case (state_q)
            IDLE: begin
                if (grant_data_s) begin
                    owner_data_d = 1'b1;
                    addr_d       = data_addr;
                    wr_d         = data_wr;
                    wstrb_d      = data_wstrb;
                    wdata_d      = data_wdata;
                    rr_data_d    = 1'b0;
                    state_d      = WAIT_ADDR;
                end else if (grant_inst_s) begin
                    // Fetches never write: write-side fields forced to zero.
                    owner_data_d = 1'b0;
                    addr_d       = inst_addr;
                    wr_d         = 1'b0;
                    wstrb_d      = 4'h0;
                    wdata_d      = 32'h0000_0000;
                    rr_data_d    = 1'b1;
                    state_d      = WAIT_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_ADDR: begin
                if (mem_addr_ok && mem_data_ok) begin
                    // Same-cycle handshake: skip WAIT_DATA entirely.
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = RESP;
                end else if (mem_addr_ok) begin
                    state_d = WAIT_DATA;
                end else begin
                    state_d = WAIT_ADDR;
                end
            end
            WAIT_DATA: begin
                if (mem_data_ok) begin
                    if (!wr_q) begin
                        rdata_d = mem_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                    state_d = RESP;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            addr_q       <= 32'h0000_0000;
            wr_q         <= 1'b0;
            wstrb_q      <= 4'h0;
            wdata_q      <= 32'h0000_0000;
            rdata_q      <= 32'h0000_0000;
            rr_data_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_data_q <= owner_data_d;
            addr_q       <= addr_d;
            wr_q         <= wr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            rr_data_q    <= rr_data_d;
        end
    end

    // Output decode; everything except addr_ok comes straight from flops.
    always_comb begin
        inst_addr_ok = grant_inst_s;
        data_addr_ok = grant_data_s;
        inst_data_ok = (state_q == RESP) && !owner_data_q;
        data_data_ok = (state_q == RESP) && owner_data_q;
        inst_rdata   = rdata_q;
        data_rdata   = rdata_q;
        mem_req      = (state_q == WAIT_ADDR);
        mem_wr       = wr_q;
        mem_wstrb    = wstrb_q;
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter. Two instances (DATA_FIRST=1 and
// DATA_FIRST=0) share all inputs; sel_rr picks which one is observed.
// A memory responder model answers requests with configurable delays, and a
// scoreboard queue holds expected completions pushed at grant time.

module tb_cpu_mem_arbiter;

    typedef struct {
        logic        is_data;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          grant_cyc;
        int          lat;
    } txn_t;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic        f_inst_addr_ok, f_inst_data_ok, f_data_addr_ok, f_data_data_ok;
    logic        f_mem_req, f_mem_wr;
    logic [3:0]  f_mem_wstrb;
    logic [31:0] f_inst_rdata, f_data_rdata, f_mem_addr, f_mem_wdata;
    logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
    logic        r_mem_req, r_mem_wr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_inst_rdata, r_data_rdata, r_mem_addr, r_mem_wdata;

    logic        sel_rr;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] inst_rdata, data_rdata, mem_addr, mem_wdata;

    assign inst_addr_ok = sel_rr ? r_inst_addr_ok : f_inst_addr_ok;
    assign inst_data_ok = sel_rr ? r_inst_data_ok : f_inst_data_ok;
    assign data_addr_ok = sel_rr ? r_data_addr_ok : f_data_addr_ok;
    assign data_data_ok = sel_rr ? r_data_data_ok : f_data_data_ok;
    assign inst_rdata   = sel_rr ? r_inst_rdata   : f_inst_rdata;
    assign data_rdata   = sel_rr ? r_data_rdata   : f_data_rdata;
    assign mem_req      = sel_rr ? r_mem_req      : f_mem_req;
    assign mem_wr       = sel_rr ? r_mem_wr       : f_mem_wr;
    assign mem_wstrb    = sel_rr ? r_mem_wstrb    : f_mem_wstrb;
    assign mem_addr     = sel_rr ? r_mem_addr     : f_mem_addr;
    assign mem_wdata    = sel_rr ? r_mem_wdata    : f_mem_wdata;

    cpu_mem_arbiter #(.DATA_FIRST(1)) u_dut_fixed (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(f_inst_addr_ok), .inst_data_ok(f_inst_data_ok), .inst_rdata(f_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(f_data_addr_ok), .data_data_ok(f_data_data_ok), .data_rdata(f_data_rdata),
        .mem_req(f_mem_req), .mem_wr(f_mem_wr), .mem_wstrb(f_mem_wstrb),
        .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    cpu_mem_arbiter #(.DATA_FIRST(0)) u_dut_rr (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(r_inst_addr_ok), .inst_data_ok(r_inst_data_ok), .inst_rdata(r_inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(r_data_addr_ok), .data_data_ok(r_data_data_ok), .data_rdata(r_data_rdata),
        .mem_req(r_mem_req), .mem_wr(r_mem_wr), .mem_wstrb(r_mem_wstrb),
        .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    int          n_checks;
    int          n_fail;
    int          cyc;
    int          ad_cfg;
    int          dd_cfg;
    int          acnt;
    int          dcnt;
    logic        pend;
    logic [31:0] paddr;
    logic        mem_en;
    logic [31:0] exp_rd;
    txn_t        rsp_q[$];
    txn_t        mem_q[$];
    logic        grant_log[$];
    txn_t        mon_t;
    txn_t        mem_t;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Memory contents as seen by the bench.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        if (a == 32'hBFC0_0000) begin
            return 32'h3C08_0001;
        end else if (a == 32'h8000_0040) begin
            return 32'hDEAD_BEEF;
        end else begin
            return a ^ 32'hA5A5_5A5A;
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Memory responder: drives handshakes at the negative edge.
    initial begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0000_0000;
        pend        = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b0;
                mem_rdata   = $urandom;
                if (!resetn) begin
                    pend = 1'b0;
                    acnt = ad_cfg;
                end else if (pend) begin
                    if (dcnt == 0) begin
                        mem_data_ok = 1'b1;
                        mem_rdata   = mem_model(paddr);
                        pend        = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end else if (mem_req) begin
                    if (mem_q.size() == 0) begin
                        check_eq("mem_unexpected_req", 64'(mem_req), 64'(0));
                    end else begin
                        mem_t = mem_q[0];
                        check_eq("mem_addr", 64'(mem_addr), 64'(mem_t.addr));
                        check_eq("mem_ctl", 64'({mem_wr, mem_wstrb, mem_wdata}),
                                 64'({mem_t.wr, mem_t.wstrb, mem_t.wdata}));
                        if (acnt == 0) begin
                            void'(mem_q.pop_front());
                            mem_addr_ok = 1'b1;
                            acnt        = ad_cfg;
                            if (dd_cfg == 0) begin
                                mem_data_ok = 1'b1;
                                mem_rdata   = mem_model(mem_t.addr);
                            end else begin
                                pend  = 1'b1;
                                paddr = mem_t.addr;
                                dcnt  = dd_cfg - 1;
                            end
                        end else begin
                            acnt--;
                        end
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every data_ok cycle.
    initial begin
        exp_rd = 32'h0000_0000;
        forever begin
            @(negedge clk);
            if (resetn && (inst_data_ok || data_data_ok)) begin
                if (rsp_q.size() == 0) begin
                    check_eq("unexpected_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
                end else begin
                    mon_t = rsp_q.pop_front();
                    check_eq("resp_port", 64'({inst_data_ok, data_data_ok}),
                             mon_t.is_data ? 64'(2'b01) : 64'(2'b10));
                    check_eq("resp_latency", 64'(cyc - mon_t.grant_cyc), 64'(mon_t.lat));
                    if (!mon_t.wr) begin
                        exp_rd = mem_model(mon_t.addr);
                    end
                    check_eq("inst_rdata", 64'(inst_rdata), 64'(exp_rd));
                    check_eq("data_rdata", 64'(data_rdata), 64'(exp_rd));
                end
            end
        end
    end

    task automatic set_mem(input int a, input int d);
        ad_cfg = a;
        dd_cfg = d;
        acnt   = a;
    endtask

    task automatic drive_inst(input logic [31:0] a);
        txn_t t;
        bit   got;
        @(posedge clk);
        #1;
        inst_req  = 1'b1;
        inst_addr = a;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (inst_addr_ok) begin
                got = 1'b1;
                check_eq("one_in_flight", 64'(rsp_q.size()), 64'(0));
                t.is_data = 1'b0; t.wr = 1'b0; t.wstrb = 4'h0; t.addr = a;
                t.wdata = 32'h0; t.grant_cyc = cyc; t.lat = 2 + ad_cfg + dd_cfg;
                rsp_q.push_back(t);
                mem_q.push_back(t);
                grant_log.push_back(1'b0);
            end
        end
        if (!got) check_eq("inst_grant_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        inst_req  = 1'b0;
        inst_addr = $urandom;
    endtask

    task automatic drive_data(input logic wr, input logic [3:0] ws, input logic [31:0] a,
                              input logic [31:0] wd);
        txn_t t;
        bit   got;
        @(posedge clk);
        #1;
        data_req   = 1'b1;
        data_wr    = wr;
        data_wstrb = ws;
        data_addr  = a;
        data_wdata = wd;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (data_addr_ok) begin
                got = 1'b1;
                check_eq("one_in_flight", 64'(rsp_q.size()), 64'(0));
                t.is_data = 1'b1; t.wr = wr; t.wstrb = ws; t.addr = a;
                t.wdata = wd; t.grant_cyc = cyc; t.lat = 2 + ad_cfg + dd_cfg;
                rsp_q.push_back(t);
                mem_q.push_back(t);
                grant_log.push_back(1'b1);
            end
        end
        if (!got) check_eq("data_grant_timeout", 64'(got), 64'(1));
        @(posedge clk);
        #1;
        data_req   = 1'b0;
        data_wr    = 1'($urandom);
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
    endtask

    task automatic wait_quiet();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if ((rsp_q.size() == 0) && !mem_req) done = 1'b1;
        end
        if (!done) check_eq("quiet_timeout", 64'(rsp_q.size()), 64'(0));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        rsp_q.delete();
        mem_q.delete();
        grant_log.delete();
        exp_rd = 32'h0000_0000;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic exp_rr[4];
        n_checks    = 0;
        n_fail      = 0;
        sel_rr      = 1'b0;
        mem_en      = 1'b1;
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h0;
        data_req    = 1'b1;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        set_mem(0, 0);

        // Reset state, with both requests raised to confirm addr_ok stays low.
        repeat (3) @(posedge clk);
        #2;
        check_eq("rst_flags", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                                   mem_req, mem_wr, mem_wstrb}), 64'(0));
        check_eq("rst_rdata", 64'({inst_rdata, data_rdata}), 64'(0));
        check_eq("rst_mem", 64'({mem_addr, mem_wdata}), 64'(0));
        inst_req = 1'b0;
        data_req = 1'b0;
        #1;
        resetn = 1'b1;

        // Fetch with same-cycle accept, data two cycles later.
        set_mem(0, 2);
        drive_inst(32'hBFC0_0000);
        wait_quiet();

        // Same-cycle addr/data handshake: data_ok at grant+2.
        set_mem(0, 0);
        drive_data(1'b0, 4'h0, 32'h8000_0040, 32'h0);
        wait_quiet();

        // Store held through a slow accept; rdata must stay at DEADBEEF.
        set_mem(3, 1);
        drive_data(1'b1, 4'h3, 32'h1FAF_0000, 32'h1234_5678);
        wait_quiet();

        // Store with no byte enables still completes.
        set_mem(1, 0);
        drive_data(1'b1, 4'h0, 32'h0000_1000, 32'hCAFE_F00D);
        wait_quiet();

        // Mixed traffic with assorted memory delays.
        for (int k = 0; k < 8; k++) begin
            set_mem(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            case (k % 3)
                0: drive_inst($urandom & 32'hFFFF_FFFC);
                1: drive_data(1'b0, 4'h0, $urandom & 32'hFFFF_FFFC, 32'h0);
                default: drive_data(1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
            endcase
            wait_quiet();
        end

        // Simultaneous requests with fixed data priority.
        set_mem(1, 1);
        grant_log.delete();
        fork
            drive_data(1'b0, 4'h0, 32'h0000_2000, 32'h0);
            drive_inst(32'h0000_3000);
            begin
                @(posedge clk);
                @(negedge clk);
                check_eq("tie_grant", 64'({data_addr_ok, inst_addr_ok}), 64'(2'b10));
            end
        join
        wait_quiet();
        check_eq("tie_order_len", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            check_eq("tie_order", 64'({grant_log[0], grant_log[1]}), 64'(2'b10));
        end

        // Stray memory handshakes while IDLE must be ignored.
        mem_en = 1'b0;
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h1111_2222;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stray_quiet", 64'({mem_req, inst_data_ok, data_data_ok}), 64'(0));
            check_eq("stray_rdata", 64'(data_rdata), 64'(exp_rd));
        end
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_en      = 1'b1;

        // Reset while waiting for data: everything drops at once, no data_ok later.
        set_mem(0, 5);
        drive_data(1'b0, 4'h0, 32'h0000_4440, 32'h0);
        @(posedge clk);
        #3;
        check_eq("pre_rst_inflight", 64'({mem_req, 1'(rsp_q.size())}), 64'(2'b01));
        resetn = 1'b0;
        #1;
        check_eq("rst_flags", 64'({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok,
                                   mem_req, mem_wr, mem_wstrb}), 64'(0));
        check_eq("rst_rdata", 64'({inst_rdata, data_rdata}), 64'(0));
        check_eq("rst_mem", 64'({mem_addr, mem_wdata}), 64'(0));
        rsp_q.delete();
        mem_q.delete();
        exp_rd = 32'h0000_0000;
        repeat (8) @(posedge clk);
        #1;
        resetn = 1'b1;
        set_mem(1, 0);
        repeat (8) @(negedge clk);
        drive_inst(32'h0000_5550);
        wait_quiet();

        // Round-robin instance: continuous requests alternate data, inst, data, inst.
        sel_rr = 1'b1;
        do_reset();
        set_mem(0, 0);
        fork
            begin
                drive_data(1'b0, 4'h0, 32'h0000_6000, 32'h0);
                drive_data(1'b0, 4'h0, 32'h0000_6004, 32'h0);
            end
            begin
                drive_inst(32'h0000_7000);
                drive_inst(32'h0000_7004);
            end
        join
        wait_quiet();
        exp_rr[0] = 1'b1; exp_rr[1] = 1'b0; exp_rr[2] = 1'b1; exp_rr[3] = 1'b0;
        check_eq("rr_len", 64'(grant_log.size()), 64'(4));
        if (grant_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                check_eq("rr_order", 64'(grant_log[k]), 64'(exp_rr[k]));
            end
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
